// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and default widths for the register-bank arbiter
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, wrapping
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any                         = 1'b1;
                idx                         = IW'((int'(ptr) + i) % N);
                grant[(int'(ptr) + i) % N]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin arbiter sharing one single-port register bank
// Optional address range check enabled by defining REG_ARB_ADDR_CHECK_EN.
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        bank_en,
    output logic                        bank_we,
    output logic [ADDR_W-1:0]           bank_addr,
    output logic [DATA_W-1:0]           bank_wdata,
    input  logic [DATA_W-1:0]           bank_rdata
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_cfg
        $error("reg_bank_arbiter: NUM_REQ must be >= 2 and NUM_REGS <= 2**ADDR_W");
    end

    state_t              state, state_nxt;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       g_idx;
    logic [IW-1:0]       lat_idx;
    logic [NUM_REQ-1:0]  grant;
    logic                any;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   rdata_q;
    logic                addr_bad;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (g_idx),
        .any   (any)
    );

    assign sel_addr  = req_addr[g_idx*ADDR_W +: ADDR_W];
    assign rsp_rdata = rdata_q;

`ifdef REG_ARB_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);
    logic err_q;

    assign addr_bad = ({1'b0, sel_addr} >= REG_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && any) begin
            err_q <= addr_bad;
        end
    end

    assign rsp_err = err_q && (state == RESP);
`else
    assign addr_bad = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            lat_idx   <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any) begin
                        lat_idx   <= g_idx;
                        lat_we    <= req_we[g_idx];
                        lat_addr  <= sel_addr;
                        lat_wdata <= req_wdata[g_idx*DATA_W +: DATA_W];
                        if (addr_bad) begin
                            rdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // a write response reports zero read data
                    if (lat_we) begin
                        rdata_q <= '0;
                    end
                end
                CAPTURE: rdata_q <= bank_rdata;
                RESP: ptr <= (lat_idx == IW'(NUM_REQ - 1)) ? '0 : lat_idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        rsp_valid  = '0;
        bank_en    = 1'b0;
        bank_we    = 1'b0;
        bank_addr  = '0;
        bank_wdata = '0;
        case (state)
            IDLE: begin
                if (any && !rst) begin
                    req_ready = grant;
                    state_nxt = addr_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                bank_en    = 1'b1;
                bank_we    = lat_we;
                bank_addr  = lat_addr;
                bank_wdata = lat_wdata;
                state_nxt  = lat_we ? RESP : CAPTURE;
            end
            CAPTURE: state_nxt = RESP;
            RESP: begin
                rsp_valid[lat_idx] = 1'b1;
                state_nxt          = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - self-checking bench for reg_bank_arbiter with bank model and scoreboard
module tb_reg_bank_arbiter;

    localparam int NREQ  = 2;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int NREGS = 32;
`ifdef REG_ARB_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               preload = 1'b1;
    logic [NREQ-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]      rsp_rdata, bank_wdata, bank_rdata;
    logic               rsp_err, bank_en, bank_we;
    logic [AW-1:0]      bank_addr;

    logic               pv  [NREQ];
    logic               pwe [NREQ];
    logic [AW-1:0]      pad [NREQ];
    logic [DW-1:0]      pwd [NREQ];

    for (genvar p = 0; p < NREQ; p++) begin : g_pack
        assign req_valid[p]          = pv[p];
        assign req_we[p]             = pwe[p];
        assign req_addr[p*AW +: AW]  = pad[p];
        assign req_wdata[p*DW +: DW] = pwd[p];
    end

    reg_bank_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    // Register bank model; off-cycle read data is junk so mistimed captures show up.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (bank_en && bank_we) begin
            mem[bank_addr] <= bank_wdata;
        end
        bank_rdata <= (bank_en && !bank_we) ? mem[bank_addr] : 32'h5A5A5A5A;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [NREQ-1:0] mask;
        logic [DW-1:0]   rdata;
        bit              err;
        int              due;
    } sb_t;

    sb_t           sb_q[$];
    int            grant_log[$];
    logic [DW-1:0] ref_mem [256];
    int            skips [NREQ];

    // Scoreboard: expectations pushed at handshake, compared at rsp_valid.
    always @(negedge clk) begin
        sb_t e;
        int  g;
        if (preload) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        end
        if (rst || preload) begin
            sb_q.delete();
            for (int p = 0; p < NREQ; p++) skips[p] = 0;
        end else begin
            if (|rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_port",  64'(rsp_valid), 64'(e.mask));
                    check("sb_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check("sb_err",   64'(rsp_err),   64'(e.err));
                    check("sb_lat",   64'(cyc),       64'(e.due));
                end
            end
            if (|(req_valid & req_ready)) begin
                check("ready_onehot", 64'($countones(req_ready)), 64'd1);
                g = 0;
                for (int p = 0; p < NREQ; p++) if (req_ready[p]) g = p;
                grant_log.push_back(g);
                for (int p = 0; p < NREQ; p++) if (p != g && req_valid[p]) skips[p]++;
                check("rr_wait_bound", 64'(skips[g] <= NREQ - 1), 64'd1);
                skips[g] = 0;
                e.mask = NREQ'(1) << g;
                if (CHK && int'(pad[g]) >= NREGS) begin
                    e.rdata = '0; e.err = 1'b1; e.due = cyc + 1;
                end else if (pwe[g]) begin
                    ref_mem[pad[g]] = pwd[g];
                    e.rdata = '0; e.err = 1'b0; e.due = cyc + 2;
                end else begin
                    e.rdata = ref_mem[pad[g]]; e.err = 1'b0; e.due = cyc + 3;
                end
                sb_q.push_back(e);
            end
        end
    end

    task automatic port_req(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 1'b0;
        pv[p] = 1'b1; pwe[p] = we; pad[p] = a; pwd[p] = d;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (req_ready[p]) begin got = 1'b1; break; end
        end
        if (!got) check($sformatf("ready_timeout_p%0d", p), 64'd0, 64'd1);
        @(posedge clk); #1;
        pv[p] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && sb_q.size() != 0; k++) @(negedge clk);
        check("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        int            exp_lat;
    } vec_t;

    localparam int NV = 9;
    vec_t vt [NV];
    int   rdy_c, rsp_c, nrsp;
    bit   got;

    initial begin
        for (int p = 0; p < NREQ; p++) begin pv[p] = 0; pwe[p] = 0; pad[p] = '0; pwd[p] = '0; end

        vt[0] = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2};
        vt[1] = '{0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3};
        vt[2] = '{1, 1'b0, 8'h05, 32'h0,        32'hC0DE0005, 1'b0, 3};
        vt[3] = '{1, 1'b1, 8'h05, 32'h12345678, 32'h0,        1'b0, 2};
        vt[4] = '{0, 1'b0, 8'h05, 32'h0,        32'h12345678, 1'b0, 3};
        vt[5] = '{1, 1'b1, 8'h1F, 32'hCAFEF00D, 32'h0,        1'b0, 2};
        vt[6] = '{0, 1'b0, 8'h1F, 32'h0,        32'hCAFEF00D, 1'b0, 3};
        if (CHK) vt[7] = '{1, 1'b0, 8'h20, 32'h0, 32'h0, 1'b1, 1};
        else     vt[7] = '{1, 1'b0, 8'h20, 32'h0, 32'hC0DE0020, 1'b0, 3};
        vt[8] = '{0, 1'b0, 8'h00, 32'h0,        32'hC0DE0000, 1'b0, 3};

        repeat (3) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        check("reset_ctrl",  64'({req_ready, rsp_valid, rsp_err, bank_en, bank_we, bank_addr}), 64'd0);
        check("reset_rdata", 64'(rsp_rdata),  64'd0);
        check("reset_wdata", 64'(bank_wdata), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed vectors, one request at a time
        for (int i = 0; i < NV; i++) begin
            pv[vt[i].port] = 1'b1; pwe[vt[i].port] = vt[i].we;
            pad[vt[i].port] = vt[i].addr; pwd[vt[i].port] = vt[i].wdata;
            got = 1'b0;
            for (int k = 0; k < 32; k++) begin
                @(negedge clk);
                if (req_ready[vt[i].port]) begin got = 1'b1; break; end
            end
            check($sformatf("v%0d_ready", i), 64'(req_ready), got ? 64'(NREQ'(1) << vt[i].port) : 64'hFFFF);
            rdy_c = cyc;
            @(posedge clk); #1 pv[vt[i].port] = 1'b0;
            got = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    if (vt[i].exp_err) begin
                        check($sformatf("v%0d_bank_en", i), 64'(bank_en), 64'd0);
                    end else begin
                        check($sformatf("v%0d_bank_en", i),   64'(bank_en),   64'd1);
                        check($sformatf("v%0d_bank_we", i),   64'(bank_we),   64'(vt[i].we));
                        check($sformatf("v%0d_bank_addr", i), 64'(bank_addr), 64'(vt[i].addr));
                        if (vt[i].we) check($sformatf("v%0d_bank_wdata", i), 64'(bank_wdata), 64'(vt[i].wdata));
                    end
                end
                if (|rsp_valid) begin got = 1'b1; rsp_c = cyc; break; end
            end
            check($sformatf("v%0d_rsp_seen", i), 64'(got), 64'd1);
            if (got) begin
                check($sformatf("v%0d_rsp_port", i),  64'(rsp_valid), 64'(NREQ'(1) << vt[i].port));
                check($sformatf("v%0d_rsp_rdata", i), 64'(rsp_rdata), 64'(vt[i].exp_rdata));
                check($sformatf("v%0d_rsp_err", i),   64'(rsp_err),   64'(vt[i].exp_err));
                check($sformatf("v%0d_latency", i),   64'(rsp_c - rdy_c), 64'(vt[i].exp_lat));
            end
            @(posedge clk); #1;
        end
        wait_drain();

        // Simultaneous requests straight out of reset alternate 0,1,0,1
        do_reset();
        grant_log.delete();
        fork
            begin port_req(0, 1'b0, 8'h01, 32'h0); port_req(0, 1'b0, 8'h02, 32'h0); end
            begin port_req(1, 1'b0, 8'h03, 32'h0); port_req(1, 1'b0, 8'h04, 32'h0); end
        join
        wait_drain();
        check("t2_grants", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < grant_log.size(); i++)
            check($sformatf("t2_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

        // Port1 held continuously against four back-to-back port0 reads
        grant_log.delete();
        fork
            begin for (int n = 0; n < 4; n++) port_req(0, 1'b0, 8'(n + 8), 32'h0); end
            begin for (int n = 0; n < 4; n++) port_req(1, 1'b1, 8'(n + 20), 32'hA0A00000 | 32'(n)); end
        join
        wait_drain();
        check("t3_grants", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < grant_log.size(); i++)
            check($sformatf("t3_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

        // Reset while a read sits in CAPTURE
        pv[0] = 1'b1; pwe[0] = 1'b0; pad[0] = 8'h06;
        got = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (req_ready[0]) begin got = 1'b1; break; end
        end
        check("t4_ready", 64'(got), 64'd1);
        @(posedge clk); #1 pv[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("t4_rst_ctrl",  64'({req_ready, rsp_valid, rsp_err, bank_en, bank_we, bank_addr}), 64'd0);
        check("t4_rst_rdata", 64'(rsp_rdata),  64'd0);
        check("t4_rst_wdata", 64'(bank_wdata), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        nrsp = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (|rsp_valid) nrsp++;
        end
        check("t4_no_rsp", 64'(nrsp), 64'd0);
        @(posedge clk); #1;
        port_req(0, 1'b1, 8'h07, 32'h0BADF00D);
        port_req(1, 1'b0, 8'h07, 32'h0);
        wait_drain();

        // Randomized mixed traffic from both ports
        fork
            begin
                for (int n = 0; n < 500; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    port_req(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 39)), $urandom());
                end
            end
            begin
                for (int n = 0; n < 500; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    port_req(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 39)), $urandom());
                end
            end
        join
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
